// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, state encoding and limits for the frame-buffer write side
package mem_if_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_LEN    = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_write_sequencer.sv
// rtl/mem_write_sequencer.sv - writes a handshaked byte stream into the frame RAM from a base address
module mem_write_sequencer
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W:0]   write_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     rem_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                done_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [ADDR_W:0]     write_count_q;
    logic [ADDR_W:0]     len_clamped;

    // Any length with the top bit set is at least the RAM depth, so clamp it to one full pass.
    assign len_clamped = length[ADDR_W] ? DEPTH : length;

    assign in_ready    = (state_q == S_WRITE) && !abort;
    assign busy        = (state_q == S_WRITE);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
    assign last_addr   = last_addr_q;
    assign write_count = write_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            rem_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
            last_addr_q   <= '0;
            write_count_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        write_count_q <= '0;
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q   <= base_addr;
                            rem_q   <= len_clamped;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Abort wins over a beat presented in the same cycle; in_ready is already low.
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (in_valid) begin
                        wr_en_q       <= 1'b1;
                        wr_addr_q     <= ptr_q;
                        wr_data_q     <= in_data;
                        ptr_q         <= ptr_q + 1'b1;
                        rem_q         <= rem_q - ONE;
                        write_count_q <= write_count_q + ONE;
                        if (rem_q == ONE) begin
                            last_addr_q <= ptr_q;
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_sequencer.sv
// tb/tb_mem_write_sequencer.sv - randomized bench with a frame-level reference model for mem_write_sequencer
module tb_mem_write_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] length = '0;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] last_addr;
    logic [8:0] write_count;

    mem_write_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .last_addr(last_addr), .write_count(write_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level reference: phase 0 idle, 1 accepting beats, 2 completion cycle.
    int         m_phase = 0;
    int         m_base  = 0;
    int         m_len   = 0;
    int         m_k     = 0;
    logic       e_wr_en = 1'b0;
    logic [7:0] e_addr  = '0;
    logic [7:0] e_data  = '0;
    logic       e_done  = 1'b0;
    logic [7:0] e_last  = '0;
    logic [8:0] e_count = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_base = 0; m_len = 0; m_k = 0;
            e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
            e_last = '0; e_count = '0;
        end else begin
            e_wr_en = 1'b0;
            e_done  = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    e_count = '0;
                    m_len   = (int'(length) > 256) ? 256 : int'(length);
                    if (m_len == 0) begin
                        m_phase = 2;
                        e_done  = 1'b1;
                    end else begin
                        m_phase = 1;
                        m_base  = int'(base_addr);
                        m_k     = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (abort) begin
                    m_phase = 0;
                end else if (in_valid) begin
                    e_wr_en = 1'b1;
                    e_addr  = 8'((m_base + m_k) % 256);
                    e_data  = in_data;
                    m_k     = m_k + 1;
                    e_count = 9'(m_k);
                    if (m_k == m_len) begin
                        e_last  = e_addr;
                        m_phase = 2;
                        e_done  = 1'b1;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    int wr_seen   = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("wr_data", 32'(wr_data), 32'(e_data));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("in_ready", 32'(in_ready), 32'((m_phase == 1) && !abort));
        chk("last_addr", 32'(last_addr), 32'(e_last));
        chk("write_count", 32'(write_count), 32'(e_count));
        if (wr_en) wr_seen++;
        if (done) done_seen++;
    end

    // vmode: 0 = back-to-back, 1 = random gaps, 2 = 1,0,1,1,0,1 pattern.
    task automatic do_frame(input logic [7:0] b, input logic [8:0] len, input int vmode,
                            input int abort_at, input bit second_start);
        int  cyc;
        bit  pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wr_seen   = 0;
        done_seen = 0;
        @(negedge clk); #1;
        start = 1'b1; base_addr = b; length = len; in_valid = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); length = 9'($urandom);
        cyc = 0;
        while (m_phase != 0 && cyc < 2000) begin
            in_data = 8'($urandom);
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = pat[cyc % 6];
            endcase
            abort = (abort_at >= 0) && (m_phase == 1) && (m_k == abort_at);
            if (abort) in_valid = 1'b1;
            start = second_start && (cyc == 2);
            @(negedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; abort = 1'b0;
        chk("frame_timeout", 32'(cyc < 2000), 32'd1);
    endtask

    initial begin
        // Reset held with live inputs.
        start = 1'b1; in_valid = 1'b1; length = 9'd5; base_addr = 8'h33;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(write_count), 32'd0);
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);

        do_frame(8'h10, 9'd4, 0, -1, 1'b0);
        chk("basic_writes", 32'(wr_seen), 32'd4);
        chk("basic_done", 32'(done_seen), 32'd1);
        chk("basic_last", 32'(last_addr), 32'h13);
        chk("basic_count", 32'(write_count), 32'd4);

        do_frame(8'hFE, 9'd4, 2, -1, 1'b0);
        chk("wrap_writes", 32'(wr_seen), 32'd4);
        chk("wrap_last", 32'(last_addr), 32'h01);
        chk("wrap_done", 32'(done_seen), 32'd1);

        do_frame(8'h55, 9'd0, 0, -1, 1'b0);
        chk("zero_writes", 32'(wr_seen), 32'd0);
        chk("zero_done", 32'(done_seen), 32'd1);
        chk("zero_count", 32'(write_count), 32'd0);
        chk("zero_last", 32'(last_addr), 32'h01);

        do_frame(8'h00, 9'd300, 0, -1, 1'b0);
        chk("ovf_writes", 32'(wr_seen), 32'd256);
        chk("ovf_last", 32'(last_addr), 32'hFF);
        chk("ovf_count", 32'(write_count), 32'd256);

        do_frame(8'h20, 9'd8, 0, 3, 1'b0);
        chk("abort_writes", 32'(wr_seen), 32'd3);
        chk("abort_done", 32'(done_seen), 32'd0);
        chk("abort_count", 32'(write_count), 32'd3);
        chk("abort_last", 32'(last_addr), 32'hFF);

        do_frame(8'h80, 9'd6, 0, -1, 1'b1);
        chk("busy_start_writes", 32'(wr_seen), 32'd6);
        chk("busy_start_last", 32'(last_addr), 32'h85);

        // Reset pulled between clock edges in the middle of a frame.
        @(negedge clk); #1;
        start = 1'b1; base_addr = 8'h40; length = 9'd20;
        @(negedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            in_data = 8'($urandom);
            @(negedge clk); #1;
        end
        #1;
        chk("mid_wr_en_before", 32'(wr_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_wr_en_async", 32'(wr_en), 32'd0);
        chk("mid_count_async", 32'(write_count), 32'd0);
        in_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;

        do_frame(8'h07, 9'd5, 1, -1, 1'b0);
        chk("after_rst_writes", 32'(wr_seen), 32'd5);
        chk("after_rst_last", 32'(last_addr), 32'h0B);

        for (int i = 0; i < 25; i++) begin
            logic [8:0] l;
            int         ab;
            l  = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 40));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            do_frame(8'($urandom), l, int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
